axis_pe_seq: RTL and testbench
==============================

Name: axis_pe_seq

Overview:
- Frame-level sequencer for the 8-bit processing element (PE) datapath.
- Accepts an AXI-Stream of packed operand beats and runs the PE multiply-accumulate once per beat: y_next = y + a*b.
- Feeds each result back as the next y, so a whole frame reduces to a dot product plus bias.
- Emits one result beat per input frame, carrying the beat count. Sits between the DMA MM2S/S2MM streams in place of the per-beat PE wrapper.

Parameters:
- WIDTH, 8, operand/accumulator width; a, b, y fields and arithmetic are WIDTH bits.
- CNT_WIDTH, 16, beat counter width; counter saturates at all-ones.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- en  in  1  frame-start enable, sampled only in IDLE
- s_axis_tready  out  1  slave ready
- s_axis_tdata  in  32  [7:0]=a, [15:8]=b, [23:16]=bias y (first beat of frame only), [31:24] ignored
- s_axis_tvalid  in  1  slave valid
- s_axis_tlast  in  1  last beat of frame
- m_axis_tready  in  1  master ready
- m_axis_tdata  out  32  [7:0]=accumulator, [15:8]=0, [31:16]=beat count, zero-extended/truncated to 16 bits
- m_axis_tvalid  out  1  master valid
- m_axis_tlast  out  1  always equal to m_axis_tvalid (one-beat output frames)
- busy  out  1  high in ACC or OUT
- frames_done  out  CNT_WIDTH  count of completed output handshakes, wraps

Behaviour:
- Reset (asynchronous, aresetn=0):
  - State goes to IDLE.
  - acc, beat count, frames_done, m_axis_tvalid, m_axis_tdata and busy all go to 0.
  - s_axis_tready goes to 0.
  - Takes effect immediately, including mid-frame or mid-output. A partial frame is discarded; no output beat is produced for it.
- Input handshake: a beat is accepted when s_axis_tvalid && s_axis_tready on a rising edge of aclk.
- s_axis_tready is a registered-state function, not combinational from m_axis_tready:
  - IDLE: equals en.
  - ACC: 1.
  - OUT: 0.
- State IDLE:
  - On an accepted beat: acc <= (bias + a*b) mod 2^WIDTH; count <= 1.
  - If tlast on that beat, go to OUT; otherwise go to ACC.
  - If en=0, no beat is accepted and the state stays IDLE.
- State ACC:
  - On an accepted beat: acc <= (acc + a*b) mod 2^WIDTH, with the bias field ignored; count <= count+1, saturating.
  - If tlast, go to OUT.
  - en is ignored in ACC; a frame that has started always completes.
- State OUT:
  - m_axis_tvalid=1; m_axis_tdata is stable and registered, valid from the first OUT cycle.
  - On m_axis_tready=1: frames_done++, m_axis_tvalid<=0, go to IDLE.
  - m_axis_tdata must not change while valid and not ready.
- Arithmetic: the product a*b is computed to 2*WIDTH bits, then the sum is truncated to WIDTH bits (modular wrap, no saturation).
- Latency:
  - The last input beat is accepted at edge N; m_axis_tvalid=1 in the cycle after edge N.
  - On the output handshake at edge M, s_axis_tready is back at en in the cycle after M (one idle-bubble cycle per frame).
- Boundaries:
  - Single-beat frame (tlast on the first beat) is legal and goes IDLE→OUT directly.
  - At count saturation, a further beat keeps count at all-ones and accumulation continues.
  - tvalid low mid-frame: hold state and acc, no timeout.
  - frames_done wraps from all-ones to 0.
  - m_axis_tready asserted in a non-OUT state has no effect.
- busy = (state != IDLE).

Test Plan:
- Reset, en=1, single beat a=3, b=4, bias=5, tlast=1 → one output beat with tdata=0x0001_0011 (acc 17, count 1), tlast=1; frames_done=1.
- Three beats of a=10, b=10, bias=0, last with tlast → acc=300 mod 256=44; tdata=0x0003_002C. Bias field on beats 2 and 3 is set to 0xFF and must be ignored.
- Same frame with m_axis_tready held low 5 cycles → tvalid stays 1, tdata stays 0x0003_002C, s_axis_tready stays 0; on tready=1, exactly one handshake occurs, then s_axis_tready=1 the following cycle.
- en=0 in IDLE with tvalid=1 → s_axis_tready=0, no acceptance. Then set en=1 and start a 2-beat frame; drop en after beat 1 → frame still completes (a=2, b=3 twice, bias 1 → acc 13, count 2).
- Assert aresetn=0 after 2 beats of a 4-beat frame → all outputs 0 immediately. After release, a new 1-beat frame (a=1, b=1, bias=0) yields tdata=0x0001_0001 with no residue from the aborted frame.
- Gap insertion: tvalid low for 3 cycles between beats of a 2-beat frame → result identical to the gapless run; busy stays 1 throughout.

Source files
------------

// File: rtl/axis_pe_seq.sv
// Frame-level sequencer around the 8-bit PE multiply-accumulate.
// Each AXI-Stream input frame reduces to one output beat: bias + sum(a*b), plus the beat count.
module axis_pe_seq #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 en,
  output logic                 s_axis_tready,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frames_done
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   frames_q, frames_d;
  logic [31:0]            tdata_q, tdata_d;

  logic                   s_rdy;
  logic                   s_hs;
  logic [WIDTH-1:0]       op_a, op_b, op_y, base, mac;
  logic [2*WIDTH-1:0]     prod;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  assign op_a = WIDTH'(s_axis_tdata[7:0]);
  assign op_b = WIDTH'(s_axis_tdata[15:8]);
  assign op_y = WIDTH'(s_axis_tdata[23:16]);

  // The bias field seeds the accumulator only on the first beat of a frame.
  assign base    = (state_q == IDLE) ? op_y : acc_q;
  assign prod    = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
  assign mac     = base + prod[WIDTH-1:0];
  assign cnt_inc = (state_q == IDLE) ? CNT_WIDTH'(1)
                 : ((&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1));

  always_comb begin
    s_rdy = 1'b0;
    case (state_q)
      IDLE:    s_rdy = en;
      ACC:     s_rdy = 1'b1;
      default: s_rdy = 1'b0;
    endcase
  end

  assign s_hs = s_axis_tvalid && s_rdy;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    tdata_d  = tdata_q;
    case (state_q)
      IDLE, ACC: begin
        if (s_hs) begin
          acc_d = mac;
          cnt_d = cnt_inc;
          if (s_axis_tlast) begin
            state_d = OUT;
            tdata_d = {16'(cnt_inc), 16'(mac)};
          end else begin
            state_d = ACC;
          end
        end
      end
      OUT: begin
        if (m_axis_tready) begin
          frames_d = frames_q + CNT_WIDTH'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      tdata_q  <= tdata_d;
    end
  end

  // Gated by aresetn so ready drops the instant reset asserts, even with en high.
  assign s_axis_tready = s_rdy && aresetn;
  assign m_axis_tvalid = (state_q == OUT);
  assign m_axis_tlast  = (state_q == OUT);
  assign m_axis_tdata  = tdata_q;
  assign busy          = (state_q != IDLE);
  assign frames_done   = frames_q;

endmodule

// File: tb/tb_axis_pe_seq.sv
// Scoreboard bench for axis_pe_seq: directed frames push expected beats, a monitor pops on handshake.
// A second instance with a 3-bit counter shares the inputs to reach count saturation and frames_done wrap.
module tb_axis_pe_seq;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        en;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;

  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] frames_done;

  logic        sm_s_tready;
  logic [31:0] sm_tdata;
  logic        sm_tvalid;
  logic        sm_tlast;
  logic        sm_busy;
  logic [2:0]  sm_frames;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 aclk = ~aclk;

  axis_pe_seq #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .en(en),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .m_axis_tready(m_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .frames_done(frames_done)
  );

  axis_pe_seq #(.WIDTH(8), .CNT_WIDTH(3)) u_small (
    .aclk(aclk), .aresetn(aresetn), .en(en),
    .s_axis_tready(sm_s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .m_axis_tready(m_tready), .m_axis_tdata(sm_tdata),
    .m_axis_tvalid(sm_tvalid), .m_axis_tlast(sm_tlast),
    .busy(sm_busy), .frames_done(sm_frames)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: an output handshake occurs on the next rising edge.
  always @(negedge aclk) begin : monitor
    logic [31:0] e;
    if (aresetn && m_axis_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_unexpected: got 0x%08h, required no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        check("out_tdata", m_axis_tdata, e);
        check("out_tlast", {31'b0, m_axis_tlast}, 32'd1);
      end
    end
  end

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] y,
                           input logic last);
    bit got = 1'b0;
    s_tdata  = {8'hA5, y, b, a};
    s_tvalid = 1'b1;
    s_tlast  = last;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge aclk);
      if (s_axis_tready) got = 1'b1;
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_accept: got no s_axis_tready, required 1 within 50 cycles");
    end
  endtask

  task automatic wait_frames(input logic [15:0] target);
    for (int i = 0; i < 100; i++) begin
      if (frames_done == target) break;
      @(negedge aclk);
    end
    check("frames_done", {16'b0, frames_done}, {16'b0, target});
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn  = 1'b0;
    en       = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    #3;
    check("rst_s_tready", {31'b0, s_axis_tready}, 32'd0);
    check("rst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_m_tdata",  m_axis_tdata, 32'd0);
    check("rst_busy",     {31'b0, busy}, 32'd0);
    check("rst_frames",   {16'b0, frames_done}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // single-beat frame: 5 + 3*4 = 17
    exp_q.push_back(32'h0001_0011);
    send_beat(8'd3, 8'd4, 8'd5, 1'b1);
    wait_frames(16'd1);

    // three beats of 10*10, later bias fields ignored: 300 mod 256 = 44
    exp_q.push_back(32'h0003_002C);
    send_beat(8'd10, 8'd10, 8'h00, 1'b0);
    send_beat(8'd10, 8'd10, 8'hFF, 1'b0);
    send_beat(8'd10, 8'd10, 8'hFF, 1'b1);
    wait_frames(16'd2);

    // same frame with output back-pressure for 5 cycles
    m_tready = 1'b0;
    exp_q.push_back(32'h0003_002C);
    send_beat(8'd10, 8'd10, 8'h00, 1'b0);
    send_beat(8'd10, 8'd10, 8'hFF, 1'b0);
    send_beat(8'd10, 8'd10, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_tvalid",   {31'b0, m_axis_tvalid}, 32'd1);
      check("stall_tdata",    m_axis_tdata, 32'h0003_002C);
      check("stall_s_tready", {31'b0, s_axis_tready}, 32'd0);
    end
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("post_hs_s_tready", {31'b0, s_axis_tready}, 32'd1);
    check("post_hs_tvalid",   {31'b0, m_axis_tvalid}, 32'd0);
    check("post_hs_frames",   {16'b0, frames_done}, 32'd3);
    @(posedge aclk);
    #1;

    // en low in IDLE blocks acceptance
    en       = 1'b0;
    s_tdata  = {8'h00, 8'h07, 8'h07, 8'h07};
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("en0_s_tready", {31'b0, s_axis_tready}, 32'd0);
      check("en0_busy",     {31'b0, busy}, 32'd0);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("en0_frames", {16'b0, frames_done}, 32'd3);

    // en dropped after the first beat: frame still completes, 1 + 6 + 6 = 13
    en = 1'b1;
    exp_q.push_back(32'h0002_000D);
    send_beat(8'd2, 8'd3, 8'd1, 1'b0);
    en = 1'b0;
    send_beat(8'd2, 8'd3, 8'd0, 1'b1);
    wait_frames(16'd4);
    en = 1'b1;

    // reset mid-frame discards the partial frame
    send_beat(8'd1, 8'd2, 8'd3, 1'b0);
    send_beat(8'd1, 8'd2, 8'd0, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("mid_rst_m_tdata",  m_axis_tdata, 32'd0);
    check("mid_rst_busy",     {31'b0, busy}, 32'd0);
    check("mid_rst_s_tready", {31'b0, s_axis_tready}, 32'd0);
    check("mid_rst_frames",   {16'b0, frames_done}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    exp_q.push_back(32'h0001_0001);
    send_beat(8'd1, 8'd1, 8'd0, 1'b1);
    wait_frames(16'd1);

    // 3-cycle gap inside a frame: same result as gapless, busy held
    exp_q.push_back(32'h0002_000D);
    send_beat(8'd2, 8'd3, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("gap_busy", {31'b0, busy}, 32'd1);
    end
    @(posedge aclk);
    #1;
    send_beat(8'd2, 8'd3, 8'd0, 1'b1);
    wait_frames(16'd2);

    // 9-beat frame: the 3-bit counter instance saturates at 7
    exp_q.push_back(32'h0009_0009);
    for (int i = 0; i < 9; i++) send_beat(8'd1, 8'd1, 8'd0, (i == 8));
    @(negedge aclk);
    check("sat_small_tdata", sm_tdata, 32'h0007_0009);
    @(posedge aclk);
    #1;
    wait_frames(16'd3);

    // five more frames: the 3-bit frames_done wraps 7 -> 0
    for (int f = 0; f < 5; f++) begin
      exp_q.push_back(32'h0001_0011);
      send_beat(8'd3, 8'd4, 8'd5, 1'b1);
    end
    wait_frames(16'd8);
    check("wrap_small_frames", {29'b0, sm_frames}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
